// File: rtl/comp_if.sv
// comp_if: operand/condition bundle and comparator results for the branch comparator.
interface comp_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0] op;
  logic compout;
  logic compout_q;
  logic eq;
  logic lt;
  modport master (output a, b, op, input compout, compout_q, eq, lt);
  modport slave (input a, b, op, output compout, compout_q, eq, lt);
endinterface

// File: rtl/comp.sv
// comp: branch-condition comparator with combinational result and a registered copy.
module comp #(
  parameter int WIDTH = 32,
  parameter bit SIGNED = 1'b1
) (
  input logic clock,
  input logic reset,
  comp_if.slave bus
);
  localparam logic [2:0] BEQ = 3'b000;
  localparam logic [2:0] BGE = 3'b001;
  localparam logic [2:0] BLE = 3'b010;
  localparam logic [2:0] BGT = 3'b011;
  localparam logic [2:0] BLT = 3'b100;
  localparam logic [2:0] BNE = 3'b101;
  logic w_eq;
  logic w_lt;
  logic w_res;
  logic r_q;
  assign w_eq = bus.a == bus.b;
  assign w_lt = SIGNED ? ($signed(bus.a) < $signed(bus.b)) : (bus.a < bus.b);
  // reserved and unknown codes fall to the default so nothing latches
  always_comb begin
    w_res = 1'b0;
    case (bus.op)
      BEQ: w_res = w_eq;
      BGE: w_res = ~w_lt;
      BLE: w_res = w_lt | w_eq;
      BGT: w_res = ~w_lt & ~w_eq;
      BLT: w_res = w_lt;
      BNE: w_res = ~w_eq;
      default: w_res = 1'b0;
    endcase
  end
  always_ff @(posedge clock)
    r_q <= reset ? 1'b0 : w_res;
  assign bus.compout = w_res;
  assign bus.compout_q = r_q;
  assign bus.eq = w_eq;
  assign bus.lt = w_lt;
endmodule

// File: tb/tb_comp.sv
// tb_comp: directed checks of comp for signed and unsigned builds.
module tb_comp;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int errs = 0;
  int checks = 0;
  comp_if #(.WIDTH(32)) bs ();
  comp_if #(.WIDTH(32)) bu ();
  comp #(.WIDTH(32), .SIGNED(1'b1)) dut_s (.clock(clock), .reset(reset), .bus(bs.slave));
  comp #(.WIDTH(32), .SIGNED(1'b0)) dut_u (.clock(clock), .reset(reset), .bus(bu.slave));
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bs.a = a; bs.b = b; bs.op = op;
    bu.a = a; bu.b = b; bu.op = op;
    #1;
  endtask

  initial begin
    drive(32'd0, 32'd0, 3'b000);
    @(posedge clock); #1;
    chk("reset_q", bs.compout_q, 1'b0);
    drive(128, 128, 3'b000); chk("beq_eq", bs.compout, 1'b1); chk("eq_flag", bs.eq, 1'b1);
    chk("q_held_in_reset", bs.compout_q, 1'b0);
    drive(129, 128, 3'b000); chk("beq_ne", bs.compout, 1'b0); chk("eq_flag0", bs.eq, 1'b0);
    drive(128, 128, 3'b001); chk("bge_eq", bs.compout, 1'b1);
    drive(12, 128, 3'b001); chk("bge_lt", bs.compout, 1'b0); chk("lt_flag", bs.lt, 1'b1);
    drive(128, 12, 3'b001); chk("bge_gt", bs.compout, 1'b1); chk("lt_flag0", bs.lt, 1'b0);
    drive(128, 128, 3'b010); chk("ble_eq", bs.compout, 1'b1);
    drive(1, 128, 3'b010); chk("ble_lt", bs.compout, 1'b1);
    drive(128, 12, 3'b010); chk("ble_gt", bs.compout, 1'b0);
    drive(128, 128, 3'b011); chk("bgt_eq", bs.compout, 1'b0);
    drive(1, 128, 3'b011); chk("bgt_lt", bs.compout, 1'b0);
    drive(128, 1, 3'b011); chk("bgt_gt", bs.compout, 1'b1);
    drive(128, 128, 3'b100); chk("blt_eq", bs.compout, 1'b0);
    drive(12, 128, 3'b100); chk("blt_lt", bs.compout, 1'b1);
    drive(128, 12, 3'b100); chk("blt_gt", bs.compout, 1'b0);
    drive(128, 128, 3'b101); chk("bne_eq", bs.compout, 1'b0);
    drive(12, 128, 3'b101); chk("bne_lt", bs.compout, 1'b1);
    drive(128, 12, 3'b101); chk("bne_gt", bs.compout, 1'b1);
    drive(12, 128, 3'b110); chk("rsv110", bs.compout, 1'b0);
    drive(128, 128, 3'b111); chk("rsv111_eq", bs.compout, 1'b0);
    drive(128, 12, 3'b111); chk("rsv111_gt", bs.compout, 1'b0);
    drive(32'hFFFFFFFF, 0, 3'b100);
    chk("blt_signed", bs.compout, 1'b1);
    chk("blt_unsigned", bu.compout, 1'b0);
    chk("lt_unsigned", bu.lt, 1'b0);
    drive(32'h7FFFFFFF, 32'h80000000, 3'b011);
    chk("bgt_signed_bound", bs.compout, 1'b1);
    chk("bgt_unsigned_bound", bu.compout, 1'b0);
    drive(32'h80000000, 0, 3'b100);
    chk("blt_min_signed", bs.compout, 1'b1);
    chk("blt_min_unsigned", bu.compout, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    drive(128, 12, 3'b011);
    chk("bgt_immediate", bs.compout, 1'b1);
    chk("q_before_edge", bs.compout_q, 1'b0);
    @(posedge clock); #1;
    chk("q_after_edge", bs.compout_q, 1'b1);
    drive(128, 12, 3'b100);
    chk("q_holds", bs.compout_q, 1'b1);
    @(posedge clock); #1;
    chk("q_tracks_zero", bs.compout_q, 1'b0);
    drive(128, 12, 3'b011);
    @(posedge clock); #1;
    chk("q_back_one", bs.compout_q, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("q_reset_mid", bs.compout_q, 1'b0);
    chk("comb_during_reset", bs.compout, 1'b1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
